io_bridge: RTL and testbench

//   Responder side of the CPU data bus (Bus_addr/Bus_wen/Bus_wdata/Bus_rdata).

---
 rtl/io_bridge_pkg.sv | 51 +++++
 rtl/io_bridge_seg_scan.sv | 42 ++++
 rtl/io_bridge.sv | 115 +++++++++++
 tb/tb_io_bridge.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/io_bridge_pkg.sv
// Shared CPU/bus definitions: the RV32 opcodes used by the core, the I/O page
// location and register offsets, and the 7-segment glyph decoder.
package io_bridge_pkg;

    // Base opcodes used by the core's control unit
    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcode_e;

    // Memory-mapped I/O page (4 KiB); every other address belongs to DRAM
    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_F000;

    // Register offsets within the I/O page
    localparam logic [11:0] OFF_SEG = 12'h000;
    localparam logic [11:0] OFF_TMR = 12'h020;
    localparam logic [11:0] OFF_LED = 12'h060;
    localparam logic [11:0] OFF_SW  = 12'h070;

    // Hex nibble to active-low segments {DP,G,F,E,D,C,B,A}; DP is always off
    function automatic logic [7:0] hex7seg(input logic [3:0] v);
        logic [7:0] seg;
        case (v)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/io_bridge_seg_scan.sv
// Eight-digit multiplexed 7-segment scanner. Each digit is lit for SCAN_DIV
// clocks; the glyph is decoded combinationally from the live SEG value, so a
// SEG write shows up on the lit digit immediately without touching scan phase.
module seg_scan
    import io_bridge_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] i_seg,
    output logic [7:0]  o_dig_en,
    output logic [7:0]  o_dig_seg
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [3:0]       w_nibble;

    // Prescaler and digit index; the index steps when the prescaler wraps
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == CNT_LAST) begin
            // NOTE: non-blocking assignments keep every flop in this block
            // reading pre-edge values, so r_idx sees the old r_cnt.
            r_cnt <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_nibble  = i_seg[4*r_idx +: 4];
    assign o_dig_en  = ~(8'b1 << r_idx);
    assign o_dig_seg = hex7seg(w_nibble);

endmodule

// File: rtl/io_bridge.sv
// Responder side of the CPU data bus. Decodes each access to DRAM or the I/O
// page, owns the LED/SEG/TMR registers and the switch synchroniser, and
// returns read data combinationally in the same cycle.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter logic [31:0] IO_BASE  = IO_BASE_DEFAULT,
    parameter int          SCAN_DIV = 50000,
    parameter int          LED_W    = 24
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic [31:0]      Bus_addr,
    input  logic             Bus_wen,
    input  logic [31:0]      Bus_wdata,
    output logic [31:0]      Bus_rdata,
    output logic [13:0]      dram_addr,
    output logic             dram_wen,
    output logic [31:0]      dram_wdata,
    input  logic [31:0]      dram_rdata,
    input  logic [LED_W-1:0] sw,
    output logic [LED_W-1:0] led,
    output logic [7:0]       dig_en,
    output logic [7:0]       dig_seg
);

    logic             w_io_sel;
    logic [9:0]       w_word_off;
    logic             w_wr_seg;
    logic             w_wr_tmr;
    logic             w_wr_led;
    logic [31:0]      w_io_rdata;
    logic             w_unused_lsbs;

    logic [LED_W-1:0] r_led;
    logic [31:0]      r_seg;
    logic [31:0]      r_tmr;
    logic [LED_W-1:0] r_sw_meta;
    logic [LED_W-1:0] r_sw_sync;

    // Address decode: byte lanes are ignored, every access is a full word
    assign w_io_sel      = (Bus_addr[31:12] == IO_BASE[31:12]);
    assign w_word_off    = Bus_addr[11:2];
    assign w_unused_lsbs = &{1'b0, Bus_addr[1:0]};

    assign w_wr_seg = Bus_wen & w_io_sel & (w_word_off == OFF_SEG[11:2]);
    assign w_wr_tmr = Bus_wen & w_io_sel & (w_word_off == OFF_TMR[11:2]);
    assign w_wr_led = Bus_wen & w_io_sel & (w_word_off == OFF_LED[11:2]);

    // DRAM port: reset gates the strobe so no store can slip out mid-reset
    assign dram_addr  = Bus_addr[15:2];
    assign dram_wdata = Bus_wdata;
    assign dram_wen   = Bus_wen & ~w_io_sel & ~cpu_rst;

    // Writable I/O registers
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_led <= '0;
            r_seg <= '0;
        end else begin
            if (w_wr_led) r_led <= Bus_wdata[LED_W-1:0];
            if (w_wr_seg) r_seg <= Bus_wdata;
        end
    end

    // Free-running cycle timer; a bus write replaces that cycle's increment
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_tmr <= '0;
        end else if (w_wr_tmr) begin
            r_tmr <= Bus_wdata;
        end else begin
            r_tmr <= r_tmr + 32'd1;
        end
    end

    // Two-flop synchroniser for the asynchronous board switches
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    // I/O read mux; unmapped offsets read as zero
    always_comb begin
        // NOTE: assigning a default before the case means every path drives
        // w_io_rdata, so no latch is inferred for unmatched offsets.
        w_io_rdata = '0;
        case (w_word_off)
            OFF_SEG[11:2]: w_io_rdata = r_seg;
            OFF_TMR[11:2]: w_io_rdata = r_tmr;
            OFF_LED[11:2]: w_io_rdata = 32'(r_led);
            OFF_SW[11:2]:  w_io_rdata = 32'(r_sw_sync);
            default:       w_io_rdata = '0;
        endcase
    end

    assign Bus_rdata = w_io_sel ? w_io_rdata : dram_rdata;
    assign led       = r_led;

    seg_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_seg_scan (
        .cpu_clk   (cpu_clk),
        .cpu_rst   (cpu_rst),
        .i_seg     (r_seg),
        .o_dig_en  (dig_en),
        .o_dig_seg (dig_seg)
    );

endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge with a short scan period. Inputs change just
// after the falling edge and outputs are sampled 1 time unit later, well
// clear of the rising edge.
module tb_io_bridge;

    localparam int LED_W = 24;

    logic             cpu_clk;
    logic             cpu_rst;
    logic [31:0]      Bus_addr;
    logic             Bus_wen;
    logic [31:0]      Bus_wdata;
    logic [31:0]      Bus_rdata;
    logic [13:0]      dram_addr;
    logic             dram_wen;
    logic [31:0]      dram_wdata;
    logic [31:0]      dram_rdata;
    logic [LED_W-1:0] sw;
    logic [LED_W-1:0] led;
    logic [7:0]       dig_en;
    logic [7:0]       dig_seg;

    int total = 0;
    int bad   = 0;

    // Digit enables and glyphs for SEG = 0x8765_4321, indexed by digit
    logic [7:0] en_tab  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] seg_tab [8] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};

    io_bridge #(
        .IO_BASE  (32'hFFFF_F000),
        .SCAN_DIV (4),
        .LED_W    (LED_W)
    ) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .Bus_addr   (Bus_addr),
        .Bus_wen    (Bus_wen),
        .Bus_wdata  (Bus_wdata),
        .Bus_rdata  (Bus_rdata),
        .dram_addr  (dram_addr),
        .dram_wen   (dram_wen),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .sw         (sw),
        .led        (led),
        .dig_en     (dig_en),
        .dig_seg    (dig_seg)
    );

    // DRAM stand-in: read data is a recognisable function of the word address
    assign dram_rdata = 32'hA5A5_0000 | 32'(dram_addr);

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with a DRAM store pending: nothing may reach DRAM
        cpu_rst   = 1'b1;
        Bus_addr  = 32'h0000_0100;
        Bus_wen   = 1'b1;
        Bus_wdata = 32'hDEAD_BEEF;
        sw        = '0;
        #1;
        check("rst_led",      32'(led),      32'h0);
        check("rst_dig_en",   32'(dig_en),   32'hFE);
        check("rst_dig_seg",  32'(dig_seg),  32'hC0);
        check("rst_dram_wen", 32'(dram_wen), 32'h0);
        Bus_addr = 32'hFFFF_F020;
        #1;
        check("rst_tmr_read", Bus_rdata, 32'h0);
        Bus_wen = 1'b0;
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;

        // DRAM store and read
        @(negedge cpu_clk);
        Bus_addr  = 32'h0000_0100;
        Bus_wdata = 32'h1234_5678;
        Bus_wen   = 1'b1;
        #1;
        check("dram_wen",   32'(dram_wen), 32'h1);
        check("dram_addr",  32'(dram_addr), 32'h040);
        check("dram_wdata", dram_wdata,    32'h1234_5678);
        check("dram_read",  Bus_rdata,     32'hA5A5_0040);

        // LED write: no DRAM strobe, visible after the edge
        @(negedge cpu_clk);
        Bus_addr  = 32'hFFFF_F060;
        Bus_wdata = 32'h00AB_CDEF;
        Bus_wen   = 1'b1;
        #1;
        check("led_no_dram", 32'(dram_wen), 32'h0);
        @(negedge cpu_clk);
        Bus_wen = 1'b0;
        #1;
        check("led_out",  32'(led),  32'h00AB_CDEF);
        check("led_read", Bus_rdata, 32'h00AB_CDEF);

        // Switch synchroniser: value readable after two rising edges
        @(negedge cpu_clk);
        sw       = 24'h00F0F0;
        Bus_addr = 32'hFFFF_F070;
        #1;
        check("sw_lag0", Bus_rdata, 32'h0);
        @(negedge cpu_clk);
        #1;
        check("sw_lag1", Bus_rdata, 32'h0);
        @(negedge cpu_clk);
        #1;
        check("sw_sync", Bus_rdata, 32'h0000_F0F0);
        Bus_wdata = 32'h1234_5678;
        Bus_wen   = 1'b1;
        #1;
        check("sw_wr_no_dram", 32'(dram_wen), 32'h0);
        @(negedge cpu_clk);
        Bus_wen = 1'b0;
        #1;
        check("sw_wr_led", 32'(led),  32'h00AB_CDEF);
        check("sw_wr_ro",  Bus_rdata, 32'h0000_F0F0);

        // Timer load and wrap
        @(negedge cpu_clk);
        Bus_addr  = 32'hFFFF_F020;
        Bus_wdata = 32'hFFFF_FFFE;
        Bus_wen   = 1'b1;
        @(negedge cpu_clk);
        Bus_wen = 1'b0;
        #1;
        check("tmr_load", Bus_rdata, 32'hFFFF_FFFE);
        @(negedge cpu_clk);
        #1;
        check("tmr_inc", Bus_rdata, 32'hFFFF_FFFF);
        @(negedge cpu_clk);
        #1;
        check("tmr_wrap", Bus_rdata, 32'h0000_0000);

        // Scanner: restart phase, then load SEG on the first cycle
        @(negedge cpu_clk);
        cpu_rst = 1'b1;
        #1;
        cpu_rst   = 1'b0;
        Bus_addr  = 32'hFFFF_F000;
        Bus_wdata = 32'h8765_4321;
        Bus_wen   = 1'b1;
        @(negedge cpu_clk);
        Bus_wen = 1'b0;
        #1;
        check("scan_d0_en",  32'(dig_en),  32'hFE);
        check("scan_d0_seg", 32'(dig_seg), 32'hF9);
        check("seg_read",    Bus_rdata,    32'h8765_4321);
        repeat (2) @(negedge cpu_clk);
        #1;
        check("scan_d0_hold", 32'(dig_en), 32'hFE);
        for (int d = 1; d <= 8; d++) begin
            repeat ((d == 1) ? 1 : 4) @(negedge cpu_clk);
            #1;
            check($sformatf("scan_en_%0d", d),  32'(dig_en),  32'(en_tab[d % 8]));
            check($sformatf("scan_seg_%0d", d), 32'(dig_seg), 32'(seg_tab[d % 8]));
        end

        // Mid-scan SEG write: glyph changes at once, phase unchanged
        repeat (4) @(negedge cpu_clk);
        Bus_wdata = 32'h0000_00E0;
        Bus_wen   = 1'b1;
        @(negedge cpu_clk);
        Bus_wen = 1'b0;
        #1;
        check("midscan_en",  32'(dig_en),  32'hFD);
        check("midscan_seg", 32'(dig_seg), 32'h86);
        repeat (3) @(negedge cpu_clk);
        #1;
        check("midscan_next_en",  32'(dig_en),  32'hFB);
        check("midscan_next_seg", 32'(dig_seg), 32'hC0);

        // Async reset during a DRAM store, mid-scan, with LEDs lit
        @(negedge cpu_clk);
        Bus_addr  = 32'hFFFF_F060;
        Bus_wdata = 32'h00FF_FFFF;
        Bus_wen   = 1'b1;
        @(negedge cpu_clk);
        Bus_addr  = 32'h0000_0200;
        Bus_wdata = 32'h0000_0055;
        #1;
        check("pre_rst_dram_wen", 32'(dram_wen), 32'h1);
        check("pre_rst_led",      32'(led),      32'h00FF_FFFF);
        #1;
        cpu_rst = 1'b1;
        #1;
        check("async_dram_wen", 32'(dram_wen), 32'h0);
        check("async_led",      32'(led),      32'h0);
        check("async_dig_en",   32'(dig_en),   32'hFE);
        check("async_dig_seg",  32'(dig_seg),  32'hC0);
        Bus_addr = 32'hFFFF_F000;
        #1;
        check("async_seg_read", Bus_rdata, 32'h0);
        Bus_wen = 1'b0;
        @(negedge cpu_clk);
        #1;
        check("rst_hold_led", 32'(led), 32'h0);
        cpu_rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
